// File: rtl/matriz_leds_param_if.sv
// Button/config/display bundle for the parametrised LED-matrix puzzle controller.
// The master side drives buttons and configuration; the slave side is the controller.
interface matriz_leds_param_if #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int NBTN  = 8,
   parameter int LVL_W = 3,
   parameter int MOV_W = 16
);
   localparam int ROW_W = $clog2(ROWS);
   localparam int BTN_W = (NBTN > 1) ? $clog2(NBTN) : 1;

   logic [NBTN-1:0]      botoes;
   logic [LVL_W-1:0]     nivel;
   logic                 limpa;
   logic                 cfg_we;
   logic [BTN_W-1:0]     cfg_btn;
   logic [ROWS*COLS-1:0] cfg_mask;
   logic                 nivel_concluido;
   logic [COLS-1:0]      colunas;
   logic [ROW_W-1:0]     linhas;
   logic [MOV_W-1:0]     jogadas;
   logic                 bloqueado;

   modport master (
      output botoes, nivel, limpa, cfg_we, cfg_btn, cfg_mask,
      input  nivel_concluido, colunas, linhas, jogadas, bloqueado
   );

   modport slave (
      input  botoes, nivel, limpa, cfg_we, cfg_btn, cfg_mask,
      output nivel_concluido, colunas, linhas, jogadas, bloqueado
   );
endinterface

// File: rtl/matriz_leds_param.sv
// LED-matrix puzzle controller: edge-detected buttons toggle programmable cell masks,
// level-dependent row scan, win detection with input lock, and a saturating move counter.
module matriz_leds_param #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int NBTN     = 8,
   parameter int SCAN_DIV = 1000,
   parameter int LVL_W    = 3,
   parameter int MOV_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   matriz_leds_param_if.slave bus
);
   localparam int CELLS = ROWS * COLS;
   localparam int ROW_W = $clog2(ROWS);
   localparam int BTN_W = (NBTN > 1) ? $clog2(NBTN) : 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CELLS-1:0] r_state;
   logic [CELLS-1:0] r_mask [NBTN];
   logic [NBTN-1:0]  r_btn_q;
   logic [LVL_W-1:0] r_nivel_q;
   logic [ROW_W-1:0] r_row;
   logic [PRE_W-1:0] r_presc;
   logic             r_win;
   logic             r_lock;
   logic [MOV_W-1:0] r_mov;

   logic [NBTN-1:0]  w_rise;
   logic [CELLS-1:0] w_tog;
   logic [31:0]      w_act;
   logic             w_full;
   logic             w_clr;
   logic             w_press;

   always_comb begin
      w_rise  = bus.botoes & ~r_btn_q;
      w_clr   = bus.limpa | (bus.nivel != r_nivel_q);
      w_press = (|w_rise) & ~r_lock & ~w_clr;
      // Overlapping masks of simultaneous presses cancel, hence XOR accumulation.
      w_tog = '0;
      for (int b = 0; b < NBTN; b++)
         if (w_rise[b]) w_tog = w_tog ^ r_mask[b];
      w_act = (32'(bus.nivel) << 1) + 32'd1;
      if (w_act > 32'(ROWS)) w_act = 32'(ROWS);
      w_full = 1'b1;
      for (int r = 0; r < ROWS; r++)
         if (32'(r) < w_act && !(&r_state[r*COLS +: COLS])) w_full = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= '0;
         r_btn_q   <= '0;
         r_nivel_q <= bus.nivel;
         r_win     <= 1'b0;
         r_lock    <= 1'b0;
         r_mov     <= '0;
         for (int b = 0; b < NBTN; b++) r_mask[b] <= '0;
      end else begin
         r_btn_q   <= bus.botoes;
         r_nivel_q <= bus.nivel;
         // Out-of-range indices match no slot, so such writes fall away.
         for (int b = 0; b < NBTN; b++)
            if (bus.cfg_we && bus.cfg_btn == BTN_W'(b)) r_mask[b] <= bus.cfg_mask;
         if (w_clr) begin
            r_state <= '0;
            r_mov   <= '0;
            r_win   <= 1'b0;
            r_lock  <= 1'b0;
         end else begin
            r_win <= w_full;
            if (w_full && !r_win) r_lock <= 1'b1;
            if (w_press) begin
               r_state <= r_state ^ w_tog;
               if (r_mov != '1) r_mov <= r_mov + 1'b1;
            end
         end
      end
   end

   // A row index left outside a shrunken active window snaps back to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row   <= '0;
         r_presc <= '0;
      end else if (32'(r_row) >= w_act) begin
         r_row   <= '0;
         r_presc <= '0;
      end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
         r_presc <= '0;
         r_row   <= (32'(r_row) == w_act - 32'd1) ? '0 : r_row + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign bus.colunas         = r_state[32'(r_row)*COLS +: COLS];
   assign bus.linhas          = r_row;
   assign bus.jogadas         = r_mov;
   assign bus.nivel_concluido = r_win;
   assign bus.bloqueado       = r_lock;
endmodule

// File: tb/tb_matriz_leds_param.sv
// Bench for matriz_leds_param: table of per-cycle vectors plus hand sequences for
// scan, level shrink and async reset; expectations flow through a scoreboard queue.
module tb_matriz_leds_param;
   localparam int ROWS = 8, COLS = 8, NBTN = 6, SDIV = 4, LVL_W = 3, MOV_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matriz_leds_param_if #(.ROWS(ROWS), .COLS(COLS), .NBTN(NBTN), .LVL_W(LVL_W), .MOV_W(MOV_W)) bus ();

   matriz_leds_param #(
      .ROWS(ROWS), .COLS(COLS), .NBTN(NBTN), .SCAN_DIV(SDIV), .LVL_W(LVL_W), .MOV_W(MOV_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [7:0] col;
      logic [2:0] mov;
      logic       win;
      logic       lock;
      logic [2:0] row;
   } exp_t;

   typedef struct {
      logic [5:0] btn;
      logic       limpa;
      logic       we;
      logic [2:0] cbtn;
      logic [7:0] cm;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t ex(logic [7:0] col, int mov, logic win, logic lock, int row);
      exp_t e;
      e.col = col; e.mov = 3'(mov); e.win = win; e.lock = lock; e.row = 3'(row);
      return e;
   endfunction

   function automatic vec_t mk(logic [5:0] btn, logic limpa, logic we, logic [2:0] cbtn,
                               logic [7:0] cm, logic [7:0] col, int mov, logic win, logic lock);
      vec_t v;
      v.btn = btn; v.limpa = limpa; v.we = we; v.cbtn = cbtn; v.cm = cm;
      v.e = ex(col, mov, win, lock, 0);
      return v;
   endfunction

   task automatic drive(logic [5:0] btn, logic limpa, logic we, logic [2:0] cbtn, logic [7:0] cm);
      bus.botoes   = btn;
      bus.limpa    = limpa;
      bus.cfg_we   = we;
      bus.cfg_btn  = cbtn;
      bus.cfg_mask = {56'd0, cm};
   endtask

   task automatic check(string nm);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         if (bus.colunas !== e.col || bus.jogadas !== e.mov || bus.nivel_concluido !== e.win ||
             bus.bloqueado !== e.lock || bus.linhas !== e.row) begin
            bad++;
            $display("FAIL %s: got col=%h mov=%0d win=%b lock=%b row=%0d want col=%h mov=%0d win=%b lock=%b row=%0d",
                     nm, bus.colunas, bus.jogadas, bus.nivel_concluido, bus.bloqueado, bus.linhas,
                     e.col, e.mov, e.win, e.lock, e.row);
         end
      end
   endtask

   task automatic step(exp_t e, string nm);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(nm);
   endtask

   initial begin
      bus.nivel = '0;
      drive(6'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      rst = 1'b1;
      #1;
      sb.push_back(ex(8'h00, 0, 1'b0, 1'b0, 0));
      check("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // nivel 0: one active row, so colunas always shows row 0
      tbl.push_back(mk(6'h00, 0, 1, 3'd0, 8'h07, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h01, 0, 0, 3'd0, 8'h00, 8'h07, 1, 0, 0));
      for (int i = 0; i < 9; i++) tbl.push_back(mk(6'h01, 0, 0, 3'd0, 8'h00, 8'h07, 1, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'h07, 1, 0, 0));
      tbl.push_back(mk(6'h00, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 1, 3'd0, 8'h0F, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 1, 3'd1, 8'h3C, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h03, 0, 0, 3'd0, 8'h00, 8'h33, 1, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'h33, 1, 0, 0));
      tbl.push_back(mk(6'h01, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h01, 0, 1, 3'd0, 8'hFF, 8'h0F, 1, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'h0F, 1, 0, 0));
      tbl.push_back(mk(6'h00, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 1, 3'd0, 8'h0F, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 1, 3'd1, 8'hF0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h01, 0, 0, 3'd0, 8'h00, 8'h0F, 1, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'h0F, 1, 0, 0));
      tbl.push_back(mk(6'h02, 0, 0, 3'd0, 8'h00, 8'hFF, 2, 0, 0));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'hFF, 2, 1, 1));
      tbl.push_back(mk(6'h01, 0, 0, 3'd0, 8'h00, 8'hFF, 2, 1, 1));
      tbl.push_back(mk(6'h00, 0, 0, 3'd0, 8'h00, 8'hFF, 2, 1, 1));
      tbl.push_back(mk(6'h00, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h00, 0, 1, 3'd7, 8'hAA, 8'h00, 0, 0, 0));
      tbl.push_back(mk(6'h01, 0, 0, 3'd0, 8'h00, 8'h0F, 1, 0, 0));
      tbl.push_back(mk(6'h20, 0, 0, 3'd0, 8'h00, 8'h0F, 2, 0, 0));
      tbl.push_back(mk(6'h00, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].btn, tbl[i].limpa, tbl[i].we, tbl[i].cbtn, tbl[i].cm);
         step(tbl[i].e, $sformatf("vec%0d", i));
      end

      // Move counter saturates at 7 while presses keep toggling
      for (int n = 1; n <= 9; n++) begin
         drive(6'h01, 1'b0, 1'b0, 3'd0, 8'h00);
         step(ex((n % 2 == 1) ? 8'h0F : 8'h00, (n > 7) ? 7 : n, 1'b0, 1'b0, 0), $sformatf("sat%0d", n));
         drive(6'h00, 1'b0, 1'b0, 3'd0, 8'h00);
         @(posedge clk);
         #1;
      end

      // Scan at nivel 1 (three active rows), four cycles per row
      drive(6'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      bus.nivel = 3'd1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(6'h00, 1'b0, 1'b1, 3'd0, 8'h01);
      step(ex(8'h00, 0, 1'b0, 1'b0, 0), "scan1");
      drive(6'h01, 1'b0, 1'b0, 3'd0, 8'h00);
      step(ex(8'h01, 1, 1'b0, 1'b0, 0), "scan2");
      drive(6'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      for (int k = 3; k <= 20; k++) begin
         int r;
         r = (k / 4) % 3;
         step(ex((r == 0) ? 8'h01 : 8'h00, 1, 1'b0, 1'b0, r), $sformatf("scan%0d", k));
      end
      bus.nivel = 3'd0;
      step(ex(8'h00, 0, 1'b0, 1'b0, 0), "shrink");
      drive(6'h01, 1'b0, 1'b0, 3'd0, 8'h00);
      step(ex(8'h01, 1, 1'b0, 1'b0, 0), "post_shrink");
      step(ex(8'h01, 1, 1'b0, 1'b0, 0), "hold");

      // Asynchronous reset mid-cycle with nonzero state
      #2 rst = 1'b1;
      #1;
      sb.push_back(ex(8'h00, 0, 1'b0, 1'b0, 0));
      check("async_rst");
      drive(6'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(6'h01, 1'b0, 1'b0, 3'd0, 8'h00);
      step(ex(8'h00, 1, 1'b0, 1'b0, 0), "mask_zeroed");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
